sr_mdu_seq: RTL and testbench

Iterative multiply/divide sequencer for the schoolRISCV core, covering RV32M ops selected by funct3. It accepts one request from the control/datapath, runs a radix-2 shift/add or shift/subtract loop over XLEN cycles, and returns one result. While busy it drives a stall that freezes the PC and register write-back. It sits beside the ALU and is sequenced by the decoder's M-extension decode.

---
 rtl/sr_mdu_seq_pkg.sv | 37 +++
 rtl/sr_mdu_iter.sv | 34 +++
 rtl/sr_mdu_seq.sv | 170 +++++++++++++++++
 tb/tb_sr_mdu_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mdu_seq_pkg.sv
// Shared definitions for the schoolRISCV RV32M multiply/divide sequencer:
// funct7/funct3 decode constants, sequencer state encoding and the
// per-op operand signedness helpers.
package sr_mdu_seq_pkg;

  // funct7 that marks an RVOP_OP instruction as an M-extension op
  localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic mdu_a_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic mdu_b_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/sr_mdu_iter.sv
// One radix-2 iteration of the mul/div loop, purely combinational.
// Multiply: conditional add of the multiplicand into the upper half, then shift right.
// Divide: restoring step on {remainder, quotient}: shift left, trial subtract, set quotient bit.
module sr_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic                w_ge;
  logic [2*XLEN-1:0]   w_div_nxt;

  // Multiply step: the carry out of the add becomes the new MSB after the shift
  assign w_sum     = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_mul_nxt = {w_sum, i_acc[XLEN-1:1]};

  // Divide step: remainder < divisor always holds, so the shifted remainder
  // fits XLEN+1 bits and the MSB of the difference is the borrow
  assign w_rem_sh  = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, i_opnd};
  assign w_ge      = ~w_diff[XLEN];
  assign w_div_nxt = w_ge ? {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1}
                          : {i_acc[2*XLEN-2:0], 1'b0};

  assign o_acc = i_div ? w_div_nxt : w_mul_nxt;

endmodule

// File: rtl/sr_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: accept, XLEN loop steps, sign fix-up, one-cycle response.
// Latency: resp_valid XLEN+2 cycles after the accept edge, 1 cycle for divide-by-zero/overflow fast path.
// Backpressure: req_ready only in IDLE; busy stalls the core until the response cycle; abort drops CALC/FIX.
module sr_mdu_seq
  import sr_mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            abort,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        r_state;
  mdu_state_t        w_state_nxt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_resp_data;

  logic              w_accept;
  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // Accept decode: abort in the same cycle suppresses the request
  assign w_accept = (r_state == MDU_IDLE) && req_valid && !abort;
  assign w_is_div = req_op[2];

  // Signs and magnitudes; negating 0x80..0 wraps to itself, which is the right unsigned magnitude
  assign w_sa    = mdu_a_signed(req_op) && req_a[XLEN-1];
  assign w_sb    = mdu_b_signed(req_op) && req_b[XLEN-1];
  assign w_mag_a = w_sa ? -req_a : req_a;
  assign w_mag_b = w_sb ? -req_b : req_b;

  // Remainder takes the dividend's sign; products and quotients take sa^sb
  assign w_neg = (req_op == MDU_REM) ? w_sa : (w_sa ^ w_sb);

  // Fast path: divide by zero and signed overflow bypass the loop
  assign w_div0     = w_is_div && (req_b == '0);
  assign w_ovf      = ((req_op == MDU_DIV) || (req_op == MDU_REM)) &&
                      (req_a == MIN_NEG) && (req_b == '1);
  assign w_fast     = w_div0 || w_ovf;
  assign w_fast_res = w_div0 ? (req_op[1] ? req_a : '1)
                             : (req_op[1] ? '0 : MIN_NEG);

  sr_mdu_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .i_div  (r_op[2]),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt)
  );

  // Sign fix-up on the finished loop result
  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_quo      = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem      = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Result select: MUL low half, MULH* high half, divides quotient or remainder
  always_comb begin
    w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    if (r_op == MDU_MUL) begin
      w_fix_res = w_prod_fix[XLEN-1:0];
    end else if (r_op[2]) begin
      w_fix_res = r_op[1] ? w_rem : w_quo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MDU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    resp_valid  = 1'b0;
    unique case (r_state)
      MDU_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          w_state_nxt = w_fast ? MDU_DONE : MDU_CALC;
        end
      end
      MDU_CALC: begin
        if (abort) begin
          w_state_nxt = MDU_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = MDU_FIX;
        end
      end
      MDU_FIX: begin
        w_state_nxt = abort ? MDU_IDLE : MDU_DONE;
      end
      MDU_DONE: begin
        resp_valid  = 1'b1;
        w_state_nxt = MDU_IDLE;
      end
      default: begin
        w_state_nxt = MDU_IDLE;
      end
    endcase
  end

  // Operand latch at accept, one loop step per CALC cycle, result capture in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= MDU_MUL;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_resp_data <= '0;
    end else if (w_accept) begin
      r_op   <= req_op;
      r_neg  <= w_neg;
      r_cnt  <= CNT_LAST;
      r_opnd <= w_is_div ? w_mag_b : w_mag_a;
      r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      if (w_fast) begin
        r_resp_data <= w_fast_res;
      end
    end else if ((r_state == MDU_CALC) && !abort) begin
      r_acc <= w_acc_nxt;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if ((r_state == MDU_FIX) && !abort) begin
      r_resp_data <= w_fix_res;
    end
  end

  assign resp_data = r_resp_data;

endmodule

// File: tb/tb_sr_mdu_seq.sv
// Self-checking bench for sr_mdu_seq: scoreboard of expected results from a
// 64-bit reference model, checked against resp_data, response cycle and busy.
module tb_sr_mdu_seq;
  import sr_mdu_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        abort;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  sr_mdu_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .abort      (abort),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference result straight from RV32M semantics using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, za, zb, p;
    int sa, sb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    sa = a;
    sb = b;
    p  = 64'd0;
    case (op)
      3'b000: begin p = za * zb; model = p[31:0]; end
      3'b001: begin p = ea * eb; model = p[63:32]; end
      3'b010: begin p = ea * zb; model = p[63:32]; end
      3'b011: begin p = za * zb; model = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
        else model = sa / sb;
      end
      3'b101: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
        else model = sa % sb;
      end
      default: model = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Issue one op (called at a negedge with the DUT idle) and check its response
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    int cyc, busy_cnt;
    bit got;
    logic [31:0] obs;
    e.data = model(op, a, b);
    e.lat  = latency(op, a, b);
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; busy_cnt = 0; got = 1'b0; obs = 32'd0;
    while (!got && cyc <= 40) begin
      if (busy) busy_cnt++;
      if (resp_valid) begin
        got = 1'b1;
        obs = resp_data;
        n_tests++;
        if (req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ready_in_done: got %b want 0", name, req_ready);
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no resp_valid within 40 cycles, want cycle %0d", name, e.lat);
    end else begin
      n_tests += 3;
      if (obs !== e.data) begin
        n_fail++;
        $display("FAIL %s data: got %h want %h", name, obs, e.data);
      end
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got cycle %0d want %0d", name, cyc, e.lat);
      end
      if (busy_cnt != e.lat) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, e.lat);
      end
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_idle: ready=%b valid=%b busy=%b want 1 0 0", name, req_ready, resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b data=%h want 1 0 0 00000000",
               req_ready, busy, resp_valid, resp_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(MDU_MUL,    32'd7,         32'hFFFF_FFFD, "mul_7_m3");
    run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    run_op(MDU_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_minmin");
    run_op(MDU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, "mulhsu_min");
  endtask

  task automatic test_div();
    run_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2,         "div_m7_2");
    run_op(MDU_REM,  32'hFFFF_FFF9, 32'd2,         "rem_m7_2");
    run_op(MDU_DIVU, 32'd100,       32'd7,         "divu_100_7");
    run_op(MDU_REMU, 32'd100,       32'd7,         "remu_100_7");
    run_op(MDU_DIV,  32'd100,       32'hFFFF_FFF9, "div_100_m7");
    run_op(MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_min_ff");
  endtask

  task automatic test_fast_path();
    run_op(MDU_DIVU, 32'd5,         32'd0,         "divu_by0");
    run_op(MDU_REM,  32'd5,         32'd0,         "rem_by0");
    run_op(MDU_DIV,  32'd5,         32'd0,         "div_by0");
    run_op(MDU_REMU, 32'hDEAD_BEEF, 32'd0,         "remu_by0");
    run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (i % 7 == 3) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  // Start a DIV, raise abort during cycle abort_cyc, and check it vanishes
  task automatic test_abort(input int abort_cyc, input string name);
    int cyc;
    bit saw;
    logic [31:0] prev;
    prev = resp_data;
    req_valid = 1'b1; req_op = MDU_DIV; req_a = 32'd1000; req_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; saw = 1'b0;
    while (cyc < abort_cyc) begin
      if (resp_valid) saw = 1'b1;
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    if (resp_valid) saw = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests += 2;
    if (saw || resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s state: saw_resp=%b valid=%b ready=%b busy=%b want 0 0 1 0",
               name, saw, resp_valid, req_ready, busy);
    end
    if (resp_data !== prev) begin
      n_fail++;
      $display("FAIL %s data_kept: got %h want %h", name, resp_data, prev);
    end
    run_op(MDU_MUL, 32'd3, 32'd4, "mul_after_abort");
  endtask

  task automatic test_abort_vs_req();
    abort = 1'b1; req_valid = 1'b1; req_op = MDU_DIVU; req_a = 32'd5; req_b = 32'd0;
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wins: valid=%b ready=%b busy=%b want 0 1 0", resp_valid, req_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int resp_cnt;
    req_valid = 1'b1; req_op = MDU_MULHU; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b data=%h want 1 0 0 00000000",
               req_ready, busy, resp_valid, resp_data);
    end
    resp_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    n_tests++;
    if (resp_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_noresp: got %0d responses want 0", resp_cnt);
    end
  endtask

  // req_valid held high for the whole op: only one op may run
  task automatic test_held_valid();
    exp_t e;
    int resp_cnt, resp_cyc;
    logic [31:0] obs;
    e.data = model(MDU_DIVU, 32'd1000, 32'd3);
    e.lat  = 34;
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = MDU_DIVU; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clk);
    resp_cnt = 0; resp_cyc = 0; obs = 32'd0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          resp_cyc  = c;
          obs       = resp_data;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    e = sb_q.pop_front();
    n_tests += 3;
    if (resp_cnt != 1) begin
      n_fail++;
      $display("FAIL held_valid_count: got %0d responses want 1", resp_cnt);
    end
    if (obs !== e.data) begin
      n_fail++;
      $display("FAIL held_valid_data: got %h want %h", obs, e.data);
    end
    if (resp_cyc != e.lat) begin
      n_fail++;
      $display("FAIL held_valid_latency: got cycle %0d want %0d", resp_cyc, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    run_op(MDU_MUL,  32'hFFFF_FFFF, 32'd2,  "b2b_mul");
    run_op(MDU_DIVU, 32'd0,         32'd0,  "b2b_fast");
    run_op(MDU_REMU, 32'd99,        32'd10, "b2b_remu");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_abort(10, "abort_calc");
    test_abort(33, "abort_fix");
    test_abort_vs_req();
    test_reset_mid();
    test_held_valid();
    test_back_to_back();
    test_random();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
